// File: rtl/interlock_out_qualifier.sv
// Purpose: synchronise and debounce raw permissive/channel lines, then drive qualified field outputs
//          with a startup hold, permissive gating and a latched over-activation fault with timed recovery.
// Latency: raw edge to output is 2 (sync) + DEBOUNCE_CYC (filter) + 1 (output register) cycles.
// Backpressure: none; the outputs are re-evaluated and registered every cycle.
// Optional: define FAULT_CNT_EN to add fault_cnt[7:0], a saturating count of RUN->FAULT entries.
module interlock_out_qualifier #(
    parameter int N_PERM       = 8,
    parameter int N_OUT        = 28,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int STARTUP_CYC  = 1000,
    parameter int MAX_ACTIVE   = 16,
    parameter int CLR_CYC      = 1000
) (
    input  logic              pclk_50M,
    input  logic              rst,
    input  logic [1:N_PERM]   outP,
    input  logic [1:N_OUT]    out,
    output logic [1:N_PERM]   eoutP,
    output logic [1:N_OUT]    eout,
`ifdef FAULT_CNT_EN
    output logic [7:0]        fault_cnt,
`endif
    output logic              fault
);

    localparam int N_ALL   = N_PERM + N_OUT;
    localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TMR_MAX = (STARTUP_CYC > CLR_CYC) ? STARTUP_CYC : CLR_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int CNT_W   = $clog2(N_OUT + 1);

    localparam logic             ACT       = ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic             INACT     = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(STARTUP_CYC - 1);
    localparam logic [TMR_W-1:0] CLR_LAST  = TMR_W'(CLR_CYC - 1);
    localparam logic [CNT_W:0]   MAX_LIM   = (CNT_W + 1)'(MAX_ACTIVE);

    typedef enum logic [1:0] {HOLD, RUN, FAULT, RECOVER} state_t;

    // Permissives occupy the upper bits, channels the lower bits; left-to-right order is preserved.
    logic [N_ALL-1:0] raw_all;
    logic [N_ALL-1:0] sync_q1;
    logic [N_ALL-1:0] sync_q2;
    logic [N_ALL-1:0] db_all;
    logic [DB_W-1:0]  db_cnt [N_ALL];
    logic [1:N_PERM]  db_perm;
    logic [1:N_OUT]   db_out;
    logic [CNT_W-1:0] active_cnt;
    logic             any_perm;
    logic             over_limit;
    logic             all_idle;
    state_t           state;
    logic [TMR_W-1:0] tmr;

    assign raw_all = {outP, out};
    assign db_perm = db_all[N_ALL-1:N_OUT];
    assign db_out  = db_all[N_OUT-1:0];

    // Two-flop synchroniser; reset parks every line at the safe level.
    always_ff @(posedge pclk_50M or posedge rst) begin
        if (rst) begin
            sync_q1 <= {N_ALL{INACT}};
            sync_q2 <= {N_ALL{INACT}};
        end else begin
            sync_q1 <= raw_all;
            sync_q2 <= sync_q1;
        end
    end

    // Per-bit debounce: the stable value only flips after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge pclk_50M or posedge rst) begin
        if (rst) begin
            db_all <= {N_ALL{INACT}};
            for (int i = 0; i < N_ALL; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ALL; i++) begin
                if (sync_q2[i] == db_all[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_all[i] <= ~db_all[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Number of debounced channels currently at the active level.
    always_comb begin
        active_cnt = '0;
        for (int i = 1; i <= N_OUT; i++) begin
            if (db_out[i] == ACT) begin
                active_cnt = active_cnt + 1'b1;
            end
        end
    end

    assign any_perm   = ACTIVE_LOW ? ~(&db_perm) : (|db_perm);
    assign over_limit = {1'b0, active_cnt} > MAX_LIM;
    assign all_idle   = (active_cnt == '0);

    // Mode sequencing with registered outputs; every non-RUN path drives the safe level, and the
    // over-limit test wins over the output update so an illegal pattern never reaches eout.
    always_ff @(posedge pclk_50M or posedge rst) begin
        if (rst) begin
            state <= HOLD;
            tmr   <= '0;
            eoutP <= {N_PERM{INACT}};
            eout  <= {N_OUT{INACT}};
            fault <= 1'b0;
        end else begin
            eoutP <= {N_PERM{INACT}};
            eout  <= {N_OUT{INACT}};
            fault <= 1'b0;
            case (state)
                HOLD: begin
                    if (tmr == HOLD_LAST) begin
                        state <= RUN;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                RUN: begin
                    if (over_limit) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else begin
                        eoutP <= db_perm;
                        eout  <= any_perm ? db_out : {N_OUT{INACT}};
                    end
                end
                FAULT: begin
                    fault <= 1'b1;
                    if (all_idle) begin
                        state <= RECOVER;
                        tmr   <= '0;
                    end
                end
                RECOVER: begin
                    if (!all_idle) begin
                        state <= FAULT;
                        tmr   <= '0;
                        fault <= 1'b1;
                    end else if (tmr == CLR_LAST) begin
                        state <= RUN;
                        tmr   <= '0;
                    end else begin
                        tmr   <= tmr + 1'b1;
                        fault <= 1'b1;
                    end
                end
                default: begin
                    state <= HOLD;
                    tmr   <= '0;
                end
            endcase
        end
    end

`ifdef FAULT_CNT_EN
    // Saturating count of fault entries from RUN; only reset clears it.
    always_ff @(posedge pclk_50M or posedge rst) begin
        if (rst) begin
            fault_cnt <= '0;
        end else if (state == RUN && over_limit && fault_cnt != 8'hFF) begin
            fault_cnt <= fault_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_interlock_out_qualifier.sv
// Bench for interlock_out_qualifier: directed test-plan sequences plus random line patterns,
// with a reference model feeding an expectation queue that a separate monitor drains every cycle.
// Also builds with FAULT_CNT_EN defined, in which case fault_cnt is scored as well.
module tb_interlock_out_qualifier;

    localparam int N_PERM  = 8;
    localparam int N_OUT   = 28;
    localparam int DEB     = 4;
    localparam int STARTUP = 10;
    localparam int MAXA    = 16;
    localparam int CLR     = 5;
    localparam int N_ALL   = N_PERM + N_OUT;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:N_PERM] outP;
    logic [1:N_OUT]  out;
    logic [1:N_PERM] eoutP;
    logic [1:N_OUT]  eout;
    logic            fault;
`ifdef FAULT_CNT_EN
    logic [7:0]      fault_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    interlock_out_qualifier #(
        .N_PERM(N_PERM), .N_OUT(N_OUT), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(DEB),
        .STARTUP_CYC(STARTUP), .MAX_ACTIVE(MAXA), .CLR_CYC(CLR)
    ) dut (
        .pclk_50M(clk),
        .rst(rst),
        .outP(outP),
        .out(out),
        .eoutP(eoutP),
        .eout(eout),
`ifdef FAULT_CNT_EN
        .fault_cnt(fault_cnt),
`endif
        .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:N_PERM] p;
        logic [1:N_OUT]  o;
        logic            f;
        logic [7:0]      fc;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state (active-low lines: all ones is the safe level).
    logic [N_ALL-1:0] m_db = '1;
    logic [N_ALL-1:0] m_r1 = '1;
    logic [N_ALL-1:0] m_r2 = '1;
    logic [N_ALL-1:0] m_hist[$];
    int m_since_rel = 0;
    bit m_in_fault  = 1'b0;
    int m_zero_run  = 0;
    int m_fcnt      = 0;

    // Model: outputs registered at this edge come from the filtered view held before the edge;
    // a filtered bit flips once its last DEB synchronised samples all disagree with it.
    always @(posedge clk) begin
        exp_t e;
        int n_act;
        bit perm_on;
        logic [N_ALL-1:0] seen;
        e.p = '1;
        e.o = '1;
        e.f = 1'b0;
        if (rst) begin
            m_db = '1; m_r1 = '1; m_r2 = '1;
            m_hist.delete();
            m_since_rel = 0; m_in_fault = 1'b0; m_zero_run = 0; m_fcnt = 0;
        end else begin
            m_since_rel++;
            n_act = 0;
            for (int b = 0; b < N_OUT; b++) if (!m_db[b]) n_act++;
            perm_on = (m_db[N_ALL-1:N_OUT] != '1);
            if (m_since_rel <= STARTUP) begin
                // startup hold: safe outputs
            end else if (!m_in_fault) begin
                if (n_act > MAXA) begin
                    m_in_fault = 1'b1;
                    m_zero_run = 0;
                    e.f = 1'b1;
                    if (m_fcnt < 255) m_fcnt++;
                end else begin
                    e.p = m_db[N_ALL-1:N_OUT];
                    e.o = perm_on ? m_db[N_OUT-1:0] : '1;
                end
            end else begin
                // one all-idle cycle to reach RECOVER, then CLR idle cycles before RUN
                m_zero_run = (n_act == 0) ? m_zero_run + 1 : 0;
                if (m_zero_run == CLR + 1) m_in_fault = 1'b0;
                else e.f = 1'b1;
            end
            seen = m_r2;
            m_r2 = m_r1;
            m_r1 = {outP, out};
            m_hist.push_back(seen);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            if (m_hist.size() == DEB) begin
                for (int b = 0; b < N_ALL; b++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    foreach (m_hist[j]) if (m_hist[j][b] == m_db[b]) all_diff = 1'b0;
                    if (all_diff) m_db[b] = ~m_db[b];
                end
            end
        end
        e.fc = 8'(m_fcnt);
        exp_q.push_back(e);
    end

    // Monitor: pops one expectation per clock and compares the registered outputs.
    initial begin
        exp_t e;
        bit fc_bad;
        forever begin
            @(posedge clk);
            #1;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                fc_bad = 1'b0;
`ifdef FAULT_CNT_EN
                fc_bad = (fault_cnt !== e.fc);
`endif
                if (eoutP !== e.p || eout !== e.o || fault !== e.f || fc_bad) begin
                    n_fail++;
                    $display("FAIL out_cycle t=%0t eoutP got %b want %b eout got %h want %h fault got %b want %b fc want %0d",
                             $time, eoutP, e.p, eout, e.o, fault, e.f, e.fc);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_safe(input string name);
        bit bad;
        n_checks++;
        bad = (eoutP !== '1) || (eout !== '1) || (fault !== 1'b0);
`ifdef FAULT_CNT_EN
        if (fault_cnt !== 8'd0) bad = 1'b1;
`endif
        if (bad) begin
            n_fail++;
            $display("FAIL %s eoutP=%b eout=%h fault=%b want all-ones outputs and fault 0", name, eoutP, eout, fault);
        end
    endtask

    // Watchdog: the run is fixed-length, so exceeding this means something is stuck.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int k;
        int idx;
        outP = 8'b11111000;
        out  = '1;
        #1 rst = 1'b1;
        #1 check_safe("reset_async");
        cyc(3);
        rst = 1'b0;
        cyc(STARTUP + 8);

        // glitch of DEB-1 cycles, then a real DEB-cycle pulse on channel 9
        out[9] = 1'b0; cyc(3); out[9] = 1'b1; cyc(10);
        out[9] = 1'b0; cyc(10); out[9] = 1'b1; cyc(10);

        // permissive gating with exactly MAXA active channels
        outP = '1; out = 28'h0F0F0F0; cyc(12);
        outP = 8'b11110101; cyc(12);

        // 17 active channels: fault
        outP = '1; out = 28'b1111111100000000000001101000; cyc(12);

        // recovery interrupted by one channel, then a clean idle period
        out = '1; cyc(3);
        out[3] = 1'b0; cyc(6);
        out[3] = 1'b1; cyc(20);
        outP = 8'b00001111; out = 28'hFFF0FFF; cyc(12);

        // separate runs: 17 then exactly 16 active channels
        out = '1;
        for (int i = 1; i <= 17; i++) out[i] = 1'b0;
        cyc(12);
        out = '1; cyc(20);
        for (int i = 1; i <= 16; i++) out[i] = 1'b0;
        cyc(12);
        out = '1; cyc(20);

        // random patterns around the activation limit, random hold times
        for (int s = 0; s < 150; s++) begin
            outP = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            out = '1;
            k = $urandom_range(0, 21);
            repeat (k) begin
                idx = $urandom_range(1, N_OUT);
                out[idx] = 1'b0;
            end
            cyc($urandom_range(1, 12));
        end

        // mid-operation reset while channels are visibly active
        outP = 8'b01111111; out = '1; cyc(25);
        out = 28'hFFFFF00; cyc(12);
        n_checks++;
        if (eout === '1) begin
            n_fail++;
            $display("FAIL midop_precond eout=%h want some active bits", eout);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_safe("reset_midop");
        cyc(2);
        rst = 1'b0;
        cyc(STARTUP + 8);

        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
